// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream, holding the core in
// reset until the last word of the frame has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              n_lo_q, n_lo_d;
  logic [15:0]             n_q, n_d;
  logic [15:0]             word_cnt_q, word_cnt_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]   asm_q, asm_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic        xfer;
  logic [15:0] n_full;

  // Status/handshake outputs are pure state decodes; address/data are held registers
  assign s_ready    = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_DATA);
  assign mem_we     = (state_q == S_WRITE);
  assign busy       = s_ready || mem_we;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign core_rst_n = (state_q == S_DONE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  assign xfer   = s_valid && s_ready;
  assign n_full = {s_data, n_lo_q};

  // State and datapath registers
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q    <= S_IDLE;
      n_lo_q     <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_lo_q     <= n_lo_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state logic; start is only honoured outside a session
  always_comb begin
    state_d    = state_q;
    n_lo_d     = n_lo_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (xfer) begin
          n_lo_d  = s_data;
          state_d = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (xfer) begin
          n_d = n_full;
          if (n_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, n_full} > 17'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            word_cnt_d = '0;
            byte_idx_d = '0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          // Shift right so the first byte of the word ends up in [7:0]
          asm_d      = {s_data, asm_q[DATA_WIDTH-1:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Capture the write beat here so it is stable for the WRITE cycle
            addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
            wdata_d = {s_data, asm_q[DATA_WIDTH-1:8]};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 16'd1;
        byte_idx_d = '0;
        state_d    = ((word_cnt_q + 16'd1) == n_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized frames checked against a
// frame-level model (expected write list plus a memory image).
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, mem_we, core_rst_n, busy, done, err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;

  int ncmp = 0;
  int nerr = 0;

  logic [63:0] act_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] mem_img [64];
  logic [31:0] exp_img [64];

  imem_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk(clk), .areset(areset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behaves as the instruction memory: records every write pulse
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      act_q.push_back({26'd0, mem_addr, mem_wdata});
      mem_img[mem_addr] = mem_wdata;
      chk("sready_in_write", {63'd0, s_ready}, 64'd0);
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    t = 0;
    while (s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 64'(t), 64'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_rst_n_low", {63'd0, core_rst_n}, 64'd0);
    chk("start_done_clr", {63'd0, done}, 64'd0);
    chk("start_busy", {63'd0, busy}, 64'd1);
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Load one frame of N words and compare writes/status against the model
  task automatic load(input int n, input bq_t d, input int gap, input bit start_mid);
    int t;
    bit bad;
    int diff;
    act_q.delete();
    exp_q.delete();
    bad = (n > 64);
    pulse_start();
    send(8'(n), gap);
    send(8'(n >> 8), gap);
    if (!bad) begin
      for (int i = 0; i < 4 * n; i++) begin
        if (start_mid && i == 1) start = 1'b1;
        send(d[i], gap);
        start = 1'b0;
      end
      for (int w = 0; w < n; w++) begin
        logic [31:0] word;
        word = {24'd0, d[4*w]} + ({24'd0, d[4*w+1]} << 8) +
               ({24'd0, d[4*w+2]} << 16) + ({24'd0, d[4*w+3]} << 24);
        exp_q.push_back({26'd0, 6'(w), word});
        exp_img[w] = word;
      end
    end
    t = 0;
    while (done !== 1'b1 && err !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("finish_timeout", {63'd0, t >= 20}, 64'd0);
    repeat (2) @(negedge clk);
    chk("done", {63'd0, done}, {63'd0, !bad});
    chk("err", {63'd0, err}, {63'd0, bad});
    chk("core_rst_n", {63'd0, core_rst_n}, {63'd0, !bad});
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("nwrites", 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk("write", act_q[i], exp_q[i]);
    diff = 0;
    for (int a = 0; a < 64; a++) if (mem_img[a] !== exp_img[a]) diff++;
    chk("mem_image", 64'(diff), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_rst_n"}, {63'd0, core_rst_n}, 64'd0);
    chk({tag, "_s_ready"}, {63'd0, s_ready}, 64'd0);
    chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_addr"}, {58'd0, mem_addr}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
  endtask

  initial begin
    bq_t d;
    for (int a = 0; a < 64; a++) begin
      mem_img[a] = '0;
      exp_img[a] = '0;
    end
    #1;
    chk_reset_outputs("reset");
    #20;
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("idle");

    // Basic load
    d = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    load(2, d, 0, 1'b0);
    chk("basic_w0", {32'd0, mem_img[0]}, 64'h00A00513);
    chk("basic_w1", {32'd0, mem_img[1]}, 64'h00500593);

    // Back-pressure: one idle cycle between bytes, start pulse while busy
    mem_img[0] = '0; mem_img[1] = '0;
    load(2, d, 1, 1'b1);

    // Boundaries
    load(0, d, 0, 1'b0);
    d.delete();
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    load(64, d, 0, 1'b0);
    chk("full_last_addr", 64'(act_q.size() == 64 ? act_q[63][37:32] : 6'd0), 64'd63);
    load(65, d, 0, 1'b0);

    // Abort mid-session after 6 data bytes
    act_q.delete();
    d = rand_bytes(8);
    pulse_start();
    send(8'd2, 0);
    send(8'd0, 0);
    for (int i = 0; i < 6; i++) send(d[i], 0);
    exp_img[0] = {d[3], d[2], d[1], d[0]};
    #2 areset = 1'b0;
    #1;
    chk_reset_outputs("abort");
    chk("abort_writes", 64'(act_q.size()), 64'd1);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    load(1, rand_bytes(4), 0, 1'b0);

    // Reload: a bigger image, then a shorter frame overwriting its start
    load(4, rand_bytes(16), 0, 1'b0);
    load(2, rand_bytes(8), 0, 1'b0);

    // Randomized frames
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 10);
      load(n, rand_bytes(4 * n), $urandom_range(0, 2), 1'($urandom));
    end
    load($urandom_range(65, 300), d, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
